// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, synchronous imem reads, 2-entry instruction FIFO,
// branch redirect with flush, and fetch stop on HALT.
module instr_fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0] START_ADDR  = '0,
  parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                imem_rd_en,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [23:0]         imem_rdata,
  output logic [23:0]         instr_out,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALTED
  } state_t;

  state_t state_q, state_d;

  logic [PC_WIDTH-1:0] pc_q;
  logic                inflight_q;
  logic [PC_WIDTH-1:0] inflight_pc_q;

  logic [23:0]         fifo_instr [2];
  logic [PC_WIDTH-1:0] fifo_pc    [2];
  logic                rd_ptr_q;
  logic                wr_ptr_q;
  logic [1:0]          count_q;

  logic       in_fetch;
  logic       do_branch;
  logic       pop;
  logic       push;
  logic       issue;
  logic       halt_push;
  logic [2:0] occupancy;

  assign in_fetch  = (state_q == S_FETCH);
  assign do_branch = in_fetch & branch_valid;
  assign pop       = instr_valid & instr_ready;
  // Slots already committed (stored + in flight) that remain after this cycle's pop.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = in_fetch & ~branch_valid & (occupancy < 3'd2);
  // Returns are dropped on a branch and whenever fetching has stopped.
  assign push      = in_fetch & inflight_q & ~branch_valid;
  assign halt_push = push & (imem_rdata[23:20] == HALT_OPCODE);

  assign imem_rd_en  = issue;
  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr_out   = instr_valid ? fifo_instr[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr_q] : '0;
  assign halted      = (state_q == S_HALTED);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (halt_push) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= START_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
      if (do_branch)  pc_q <= branch_target;
      else if (issue) pc_q <= pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (do_branch) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr_q] <= imem_rdata;
        fifo_pc[wr_ptr_q]    <= inflight_pc_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
